// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - issue/read/writeback bundle for the scoreboarded register file
interface reg_file_sb_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
);
  logic [ADDR_W-1:0]   rs1;
  logic [ADDR_W-1:0]   rs2;
  logic                use_rs1;
  logic                use_rs2;
  logic [DATA_W-1:0]   read_data1;
  logic [DATA_W-1:0]   read_data2;
  logic                iss_valid;
  logic                iss_wr;
  logic [ADDR_W-1:0]   iss_rd;
  logic                iss_accept;
  logic                hazard;
  logic                wb_en;
  logic [ADDR_W-1:0]   wb_rd;
  logic [DATA_W-1:0]   wb_data;
  logic [NUM_REGS-1:0] busy_vec;
  logic [ADDR_W:0]     busy_cnt;

  modport slave (
    input  rs1, rs2, use_rs1, use_rs2, iss_valid, iss_wr, iss_rd,
    input  wb_en, wb_rd, wb_data,
    output read_data1, read_data2, iss_accept, hazard, busy_vec, busy_cnt
  );

  modport master (
    output rs1, rs2, use_rs1, use_rs2, iss_valid, iss_wr, iss_rd,
    output wb_en, wb_rd, wb_data,
    input  read_data1, read_data2, iss_accept, hazard, busy_vec, busy_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with busy-bit scoreboard; REG_FILE_SB_BYPASS_EN enables writeback forwarding
module reg_file_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_sb_if.slave  bus
);

  localparam logic ZR = (ZERO_REG != 0);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;

  logic [NUM_REGS-1:0] busy_eff;
  logic [NUM_REGS-1:0] busy_haz;
  logic [NUM_REGS-1:0] wb_clr;
  logic [NUM_REGS-1:0] set_req;
  logic [DATA_W-1:0]   rd1, rd2;
  logic                hazard;
  logic                accept;
  logic                wb_ok;
  logic                set_ok;

  // Busy view used for stalls; R0 never reports busy when it is hardwired.
  always_comb begin
    busy_eff = busy_q;
    if (ZR) busy_eff[0] = 1'b0;
    wb_clr = '0;
    if (bus.wb_en) wb_clr[bus.wb_rd] = 1'b1;
    set_req = '0;
    if (bus.iss_valid && bus.iss_wr) set_req[bus.iss_rd] = 1'b1;
`ifdef REG_FILE_SB_BYPASS_EN
    // A register retiring this cycle no longer blocks, unless it is re-claimed now.
    busy_haz = busy_eff & ~(wb_clr & ~set_req);
`else
    busy_haz = busy_eff;
`endif
  end

  // RAW on both sources plus WAW on the destination.
  always_comb begin
    hazard = (bus.use_rs1 & busy_haz[bus.rs1]) |
             (bus.use_rs2 & busy_haz[bus.rs2]) |
             (bus.iss_wr  & busy_haz[bus.iss_rd]);
    accept = bus.iss_valid & ~hazard;
  end

  // Combinational read ports, optionally forwarding the in-flight writeback.
  always_comb begin
    rd1 = regs_q[bus.rs1];
    rd2 = regs_q[bus.rs2];
    if (ZR && (bus.rs1 == '0)) rd1 = '0;
    if (ZR && (bus.rs2 == '0)) rd2 = '0;
`ifdef REG_FILE_SB_BYPASS_EN
    if (bus.wb_en && (bus.wb_rd == bus.rs1) && !(ZR && (bus.rs1 == '0))) rd1 = bus.wb_data;
    if (bus.wb_en && (bus.wb_rd == bus.rs2) && !(ZR && (bus.rs2 == '0))) rd2 = bus.wb_data;
`endif
  end

  // Next scoreboard state: clear on writeback first so a same-index set wins.
  always_comb begin
    wb_ok  = bus.wb_en & ~(ZR & (bus.wb_rd == '0));
    set_ok = accept & bus.iss_wr & ~(ZR & (bus.iss_rd == '0));
    busy_d = busy_q;
    if (bus.wb_en) busy_d[bus.wb_rd] = 1'b0;
    if (set_ok)    busy_d[bus.iss_rd] = 1'b1;
    if (ZR)        busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
  end

  // Register array writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wb_ok) begin
      regs_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Scoreboard bits and their population count, updated together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.read_data1 = rd1;
  assign bus.read_data2 = rd2;
  assign bus.hazard     = hazard;
  assign bus.iss_accept = accept;
  assign bus.busy_vec   = busy_q;
  assign bus.busy_cnt   = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - self-checking bench for reg_file_sb (honours REG_FILE_SB_BYPASS_EN)
module tb_reg_file_sb;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  reg_file_sb_if #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3)) bus ();

  reg_file_sb #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rs1 = '0; bus.rs2 = '0; bus.use_rs1 = 1'b0; bus.use_rs2 = 1'b0;
    bus.iss_valid = 1'b0; bus.iss_wr = 1'b0; bus.iss_rd = '0;
    bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    idle();
    #1 rst_n = 1'b0;
    #1;
    bus.iss_valid = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); checks++;
    if (bus.busy_vec !== e[7:0]) begin errors++; $display("FAIL por_busy_vec got %h exp %h", bus.busy_vec, e[7:0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.busy_cnt !== e[3:0]) begin errors++; $display("FAIL por_busy_cnt got %0d exp %0d", bus.busy_cnt, e[3:0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.hazard !== e[0]) begin errors++; $display("FAIL por_hazard got %b exp %b", bus.hazard, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.iss_accept !== e[0]) begin errors++; $display("FAIL por_accept got %b exp %b", bus.iss_accept, e[0]); end
    idle();
    rst_n = 1'b1;
    tick();
    // Load R1..R7, then leave R6 pending.
    for (int i = 1; i < 8; i++) begin
      bus.wb_en = 1'b1; bus.wb_rd = 3'(i); bus.wb_data = 16'(i * 16'h1111);
      tick();
    end
    idle();
    bus.iss_valid = 1'b1; bus.iss_wr = 1'b1; bus.iss_rd = 3'd6;
    tick();
    idle();
    bus.rs1 = 3'd7; bus.rs2 = 3'd1;
    exp_q.push_back(32'h7777); exp_q.push_back(32'h1111); exp_q.push_back(32'h40);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (bus.read_data1 !== e[15:0]) begin errors++; $display("FAIL preload_r7 got %h exp %h", bus.read_data1, e[15:0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.read_data2 !== e[15:0]) begin errors++; $display("FAIL preload_r1 got %h exp %h", bus.read_data2, e[15:0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.busy_vec !== e[7:0]) begin errors++; $display("FAIL preload_busy got %h exp %h", bus.busy_vec, e[7:0]); end
    // Asynchronous clear between clock edges.
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      bus.rs1 = 3'(i); bus.rs2 = 3'(7 - i);
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #0.1;
      e = exp_q.pop_front(); checks++;
      if (bus.read_data1 !== e[15:0]) begin errors++; $display("FAIL reset_rd1[%0d] got %h exp %h", i, bus.read_data1, e[15:0]); end
      e = exp_q.pop_front(); checks++;
      if (bus.read_data2 !== e[15:0]) begin errors++; $display("FAIL reset_rd2[%0d] got %h exp %h", 7 - i, bus.read_data2, e[15:0]); end
    end
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if (bus.busy_vec !== e[7:0]) begin errors++; $display("FAIL reset_busy_vec got %h exp %h", bus.busy_vec, e[7:0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.busy_cnt !== e[3:0]) begin errors++; $display("FAIL reset_busy_cnt got %0d exp %0d", bus.busy_cnt, e[3:0]); end
    #1 rst_n = 1'b1;
    idle();
    tick();
  endtask

  task automatic test_zero_reg();
    bus.wb_en = 1'b1; bus.wb_rd = 3'd0; bus.wb_data = 16'hBEEF;
    tick();
    idle();
    bus.rs1 = 3'd0;
    bus.iss_valid = 1'b1; bus.iss_wr = 1'b1; bus.iss_rd = 3'd0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (bus.read_data1 !== e[15:0]) begin errors++; $display("FAIL r0_read got %h exp %h", bus.read_data1, e[15:0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.iss_accept !== e[0]) begin errors++; $display("FAIL r0_accept got %b exp %b", bus.iss_accept, e[0]); end
    tick();
    idle();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (bus.busy_vec !== e[7:0]) begin errors++; $display("FAIL r0_busy_vec got %h exp %h", bus.busy_vec, e[7:0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.busy_cnt !== e[3:0]) begin errors++; $display("FAIL r0_busy_cnt got %0d exp %0d", bus.busy_cnt, e[3:0]); end
    tick();
  endtask

  task automatic test_raw();
    bus.iss_valid = 1'b1; bus.iss_wr = 1'b1; bus.iss_rd = 3'd3;
    tick();
    idle();
    bus.iss_valid = 1'b1; bus.rs1 = 3'd3; bus.use_rs1 = 1'b1;
    exp_q.push_back(32'h08); exp_q.push_back(32'h1); exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (bus.busy_vec !== e[7:0]) begin errors++; $display("FAIL raw_busy_vec got %h exp %h", bus.busy_vec, e[7:0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.busy_cnt !== e[3:0]) begin errors++; $display("FAIL raw_busy_cnt got %0d exp %0d", bus.busy_cnt, e[3:0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.hazard !== e[0]) begin errors++; $display("FAIL raw_stall_hazard got %b exp %b", bus.hazard, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.iss_accept !== e[0]) begin errors++; $display("FAIL raw_stall_accept got %b exp %b", bus.iss_accept, e[0]); end
    tick();
    bus.wb_en = 1'b1; bus.wb_rd = 3'd3; bus.wb_data = 16'h00A5;
`ifdef REG_FILE_SB_BYPASS_EN
    exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h00A5);
`else
    exp_q.push_back(32'h1); exp_q.push_back(32'h0); exp_q.push_back(32'h0000);
`endif
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (bus.hazard !== e[0]) begin errors++; $display("FAIL raw_wb_hazard got %b exp %b", bus.hazard, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.iss_accept !== e[0]) begin errors++; $display("FAIL raw_wb_accept got %b exp %b", bus.iss_accept, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.read_data1 !== e[15:0]) begin errors++; $display("FAIL raw_wb_read got %h exp %h", bus.read_data1, e[15:0]); end
    tick();
    bus.wb_en = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h00A5); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (bus.hazard !== e[0]) begin errors++; $display("FAIL raw_after_hazard got %b exp %b", bus.hazard, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.iss_accept !== e[0]) begin errors++; $display("FAIL raw_after_accept got %b exp %b", bus.iss_accept, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.read_data1 !== e[15:0]) begin errors++; $display("FAIL raw_after_read got %h exp %h", bus.read_data1, e[15:0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.busy_vec !== e[7:0]) begin errors++; $display("FAIL raw_after_busy got %h exp %h", bus.busy_vec, e[7:0]); end
    idle();
    tick();
  endtask

  task automatic test_set_clear();
    // R6 pending first so the count has a non-zero base.
    bus.iss_valid = 1'b1; bus.iss_wr = 1'b1; bus.iss_rd = 3'd6;
    tick();
    // R5 written back and re-claimed in the same cycle.
    bus.iss_rd = 3'd5; bus.wb_en = 1'b1; bus.wb_rd = 3'd5; bus.wb_data = 16'h0055;
    exp_q.push_back(32'h1);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (bus.iss_accept !== e[0]) begin errors++; $display("FAIL sc_accept got %b exp %b", bus.iss_accept, e[0]); end
    tick();
    // Different indices: clear R6 while claiming R7.
    bus.iss_rd = 3'd7; bus.wb_rd = 3'd6; bus.wb_data = 16'h0066;
    bus.rs1 = 3'd5;
    exp_q.push_back(32'h60); exp_q.push_back(32'h2); exp_q.push_back(32'h0055);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (bus.busy_vec !== e[7:0]) begin errors++; $display("FAIL sc_same_busy got %h exp %h", bus.busy_vec, e[7:0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.busy_cnt !== e[3:0]) begin errors++; $display("FAIL sc_same_cnt got %0d exp %0d", bus.busy_cnt, e[3:0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.read_data1 !== e[15:0]) begin errors++; $display("FAIL sc_same_data got %h exp %h", bus.read_data1, e[15:0]); end
    tick();
    idle();
    exp_q.push_back(32'hA0); exp_q.push_back(32'h2);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (bus.busy_vec !== e[7:0]) begin errors++; $display("FAIL sc_diff_busy got %h exp %h", bus.busy_vec, e[7:0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.busy_cnt !== e[3:0]) begin errors++; $display("FAIL sc_diff_cnt got %0d exp %0d", bus.busy_cnt, e[3:0]); end
    tick();
    bus.wb_en = 1'b1; bus.wb_rd = 3'd5; tick();
    bus.wb_rd = 3'd7; tick();
    idle();
  endtask

  task automatic test_waw();
    for (int i = 0; i < 3; i++) begin
      bus.iss_valid = 1'b1; bus.iss_wr = 1'b1; bus.iss_rd = 3'(1 << i);
      tick();
    end
    idle();
    bus.iss_valid = 1'b1; bus.iss_wr = 1'b1; bus.iss_rd = 3'd2;
    exp_q.push_back(32'h16); exp_q.push_back(32'h3); exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (bus.busy_vec !== e[7:0]) begin errors++; $display("FAIL waw_busy got %h exp %h", bus.busy_vec, e[7:0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.busy_cnt !== e[3:0]) begin errors++; $display("FAIL waw_cnt got %0d exp %0d", bus.busy_cnt, e[3:0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.hazard !== e[0]) begin errors++; $display("FAIL waw_hazard got %b exp %b", bus.hazard, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.iss_accept !== e[0]) begin errors++; $display("FAIL waw_accept got %b exp %b", bus.iss_accept, e[0]); end
    tick();
    idle();
    bus.wb_en = 1'b1; bus.wb_rd = 3'd2; bus.wb_data = 16'h2222;
    tick();
    // Writeback to an idle register: data lands, no busy change.
    bus.wb_rd = 3'd3; bus.wb_data = 16'h3333;
    exp_q.push_back(32'h12); exp_q.push_back(32'h2);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (bus.busy_vec !== e[7:0]) begin errors++; $display("FAIL waw_wb_busy got %h exp %h", bus.busy_vec, e[7:0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.busy_cnt !== e[3:0]) begin errors++; $display("FAIL waw_wb_cnt got %0d exp %0d", bus.busy_cnt, e[3:0]); end
    tick();
    idle();
    bus.rs2 = 3'd3;
    exp_q.push_back(32'h12); exp_q.push_back(32'h3333);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (bus.busy_vec !== e[7:0]) begin errors++; $display("FAIL idle_wb_busy got %h exp %h", bus.busy_vec, e[7:0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.read_data2 !== e[15:0]) begin errors++; $display("FAIL idle_wb_data got %h exp %h", bus.read_data2, e[15:0]); end
  endtask

  task automatic test_reset_mid();
    // R1 and R4 still pending from the WAW scenario.
    rst_n = 1'b0;
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if (bus.busy_vec !== e[7:0]) begin errors++; $display("FAIL mid_rst_busy got %h exp %h", bus.busy_vec, e[7:0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.busy_cnt !== e[3:0]) begin errors++; $display("FAIL mid_rst_cnt got %0d exp %0d", bus.busy_cnt, e[3:0]); end
    #1 rst_n = 1'b1;
    tick();
    idle();
    bus.wb_en = 1'b1; bus.wb_rd = 3'd4; bus.wb_data = 16'h4444;
    tick();
    idle();
    bus.rs1 = 3'd4;
    exp_q.push_back(32'h4444); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (bus.read_data1 !== e[15:0]) begin errors++; $display("FAIL late_wb_data got %h exp %h", bus.read_data1, e[15:0]); end
    e = exp_q.pop_front(); checks++;
    if (bus.busy_vec !== e[7:0]) begin errors++; $display("FAIL late_wb_busy got %h exp %h", bus.busy_vec, e[7:0]); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] m_regs [8];
    logic [7:0]  m_busy, bh;
    logic        hz, acc;
    logic [15:0] r1, r2;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_busy = '0;
    tick();
    for (int c = 0; c < 300; c++) begin
      bus.rs1 = 3'($urandom_range(0, 7)); bus.rs2 = 3'($urandom_range(0, 7));
      bus.use_rs1 = 1'($urandom); bus.use_rs2 = 1'($urandom);
      bus.iss_valid = 1'($urandom); bus.iss_wr = 1'($urandom); bus.iss_rd = 3'($urandom_range(0, 7));
      bus.wb_en = 1'($urandom); bus.wb_rd = 3'($urandom_range(0, 7)); bus.wb_data = 16'($urandom);
      bh = m_busy;
`ifdef REG_FILE_SB_BYPASS_EN
      for (int i = 0; i < 8; i++)
        if (bus.wb_en && bus.wb_rd == 3'(i) && !(bus.iss_valid && bus.iss_wr && bus.iss_rd == 3'(i))) bh[i] = 1'b0;
`endif
      hz  = (bus.use_rs1 && bh[bus.rs1]) || (bus.use_rs2 && bh[bus.rs2]) || (bus.iss_wr && bh[bus.iss_rd]);
      acc = bus.iss_valid && !hz;
      r1  = (bus.rs1 == 3'd0) ? 16'h0 : m_regs[bus.rs1];
      r2  = (bus.rs2 == 3'd0) ? 16'h0 : m_regs[bus.rs2];
`ifdef REG_FILE_SB_BYPASS_EN
      if (bus.wb_en && bus.wb_rd == bus.rs1 && bus.rs1 != 3'd0) r1 = bus.wb_data;
      if (bus.wb_en && bus.wb_rd == bus.rs2 && bus.rs2 != 3'd0) r2 = bus.wb_data;
`endif
      exp_q.push_back({31'h0, hz}); exp_q.push_back({31'h0, acc});
      exp_q.push_back({16'h0, r1}); exp_q.push_back({16'h0, r2});
      exp_q.push_back({24'h0, m_busy}); exp_q.push_back(32'($countones(m_busy)));
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (bus.hazard !== e[0]) begin errors++; $display("FAIL b2b_hazard c%0d got %b exp %b", c, bus.hazard, e[0]); end
      e = exp_q.pop_front(); checks++;
      if (bus.iss_accept !== e[0]) begin errors++; $display("FAIL b2b_accept c%0d got %b exp %b", c, bus.iss_accept, e[0]); end
      e = exp_q.pop_front(); checks++;
      if (bus.read_data1 !== e[15:0]) begin errors++; $display("FAIL b2b_rd1 c%0d got %h exp %h", c, bus.read_data1, e[15:0]); end
      e = exp_q.pop_front(); checks++;
      if (bus.read_data2 !== e[15:0]) begin errors++; $display("FAIL b2b_rd2 c%0d got %h exp %h", c, bus.read_data2, e[15:0]); end
      e = exp_q.pop_front(); checks++;
      if (bus.busy_vec !== e[7:0]) begin errors++; $display("FAIL b2b_busy c%0d got %h exp %h", c, bus.busy_vec, e[7:0]); end
      e = exp_q.pop_front(); checks++;
      if (bus.busy_cnt !== e[3:0]) begin errors++; $display("FAIL b2b_cnt c%0d got %0d exp %0d", c, bus.busy_cnt, e[3:0]); end
      if (bus.wb_en && bus.wb_rd != 3'd0) m_regs[bus.wb_rd] = bus.wb_data;
      if (bus.wb_en) m_busy[bus.wb_rd] = 1'b0;
      if (acc && bus.iss_wr && bus.iss_rd != 3'd0) m_busy[bus.iss_rd] = 1'b1;
      tick();
    end
    idle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_zero_reg();
    test_raw();
    test_set_clear();
    test_waw();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the 8x16 general-purpose register file.
- Generalised register width and count; two combinational read ports and one writeback port.
- Adds an asynchronous clear and a per-register scoreboard (busy bits) that tracks pending writes.
- Raises a hazard flag to the issue stage; sits between the decode/issue stage and writeback in the pipelined core.

Parameters:
- DATA_W, 16, register width in bits
- NUM_REGS, 8, number of registers (power of two, >=2)
- ADDR_W, 3, register index width, equal to log2(NUM_REGS)
- ZERO_REG, 1, 1 = R0 reads as 0, never written, never busy; 0 = R0 is an ordinary register

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rs1  in  ADDR_W  read port 1 index
- rs2  in  ADDR_W  read port 2 index
- use_rs1  in  1  issuing instruction consumes rs1
- use_rs2  in  1  issuing instruction consumes rs2
- read_data1  out  DATA_W  contents of rs1
- read_data2  out  DATA_W  contents of rs2
- iss_valid  in  1  instruction presented for issue
- iss_wr  in  1  issuing instruction will write iss_rd
- iss_rd  in  ADDR_W  destination of issuing instruction
- iss_accept  out  1  issue taken this cycle
- hazard  out  1  issue must stall
- wb_en  in  1  writeback strobe
- wb_rd  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback value
- busy_vec  out  NUM_REGS  scoreboard bits, bit i = register i pending
- busy_cnt  out  ADDR_W+1  number of set busy bits (registered)

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - all registers, busy_vec and busy_cnt go to 0
  - combinational outputs follow from the cleared state: read_data* = 0, hazard = 0, iss_accept = iss_valid
- Reads are combinational, zero latency: read_data1 = reg[rs1]. With ZERO_REG=1 and index 0, the read returns 0.
- Write: on the rising edge with wb_en=1, reg[wb_rd] <= wb_data. The write is visible on a read port the next cycle. With ZERO_REG=1 and wb_rd=0 the write is dropped.
- hazard (combinational) = (use_rs1 & busy[rs1]) | (use_rs2 & busy[rs2]) | (iss_wr & busy[iss_rd]).
  - The last term is the WAW check.
  - Busy bits for R0 read as 0 when ZERO_REG=1.
- iss_accept = iss_valid & ~hazard.
- Scoreboard update on the rising edge:
  - set: iss_accept & iss_wr & !(ZERO_REG & iss_rd==0) sets busy[iss_rd]
  - clear: wb_en clears busy[wb_rd]
  - same index set and cleared in the same cycle: set wins, so the result is busy=1 (new producer pending)
  - different indices: both updates apply
- wb_en to a register that is not busy: the data is written and the busy bit stays 0. This is not an error.
- busy_cnt is updated in the same edge as busy_vec and always equals popcount(busy_vec). Maximum value is NUM_REGS (NUM_REGS-1 when ZERO_REG=1), so there is no overflow.
- reset asserted mid-operation: everything clears immediately; pending writebacks arriving after reset release are written but set no busy bit.

Optional Feature:
- Macro: REG_FILE_SB_BYPASS_EN
- Defined:
  - Same-cycle writeback forwarding. If wb_en & wb_rd==rsN (and not the zero register), read_dataN = wb_data.
  - hazard ignores a busy bit whose register is being written back in the current cycle (wb_en & wb_rd==index), unless that same index is also being set this cycle.
- Undefined:
  - Reads return the pre-edge register value.
  - hazard uses raw busy bits, giving one extra stall cycle per RAW dependency.

Test Plan:
- Reset: write R1..R7 with 0x1111..0x7777, pulse rst_n low with no clk edge -> all reads return 0x0000, busy_vec=0, busy_cnt=0.
- R0 protection (ZERO_REG=1):
  - wb_en, wb_rd=0, wb_data=0xBEEF -> read_data1(rs1=0)=0x0000
  - iss_rd=0 issue -> busy_vec stays 0
- RAW stall, bypass undefined:
  - issue iss_rd=3 -> busy_vec=0x08, busy_cnt=1
  - next instruction with rs1=3, use_rs1=1 -> hazard=1, iss_accept=0
  - wb_rd=3, wb_data=0x00A5 -> hazard still 1 that cycle; next cycle hazard=0, read_data1=0x00A5
- Same RAW sequence with REG_FILE_SB_BYPASS_EN -> in the writeback cycle read_data1=0x00A5, hazard=0, iss_accept=1.
- Simultaneous set and clear on R5 (busy, writeback and new issue to R5 in the same cycle) -> busy[5]=1 afterwards, busy_cnt unchanged.
- WAW and count: issue writes to R1, R2, R4 -> busy_vec=0x16, busy_cnt=3; issue iss_wr with iss_rd=2 -> hazard=1; writeback R2 -> busy_vec=0x12, busy_cnt=2.
